// File: rtl/uart_rx_frame.sv
// UART receive framer: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Synchronises rs232_rx, holds bps_start for the whole frame and samples on each clk_bps pulse.
module uart_rx_frame (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    input  logic       clk_bps,
    output logic       bps_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t     state_q;
    logic       s0_q;
    logic       s1_q;
    logic       s2_q;
    logic       start_edge;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [7:0] bit_sel;
    logic       data_bit_en;
    logic       bps_start_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       rx_busy_q;
`ifdef UART_RX_PARITY_EN
    logic       parity_bit_q;
    logic       parity_err_q;
    logic       parity_bad;
`endif

    // s2 still holds the previous (high) level when s1 first shows the low start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s0_q <= rs232_rx;
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign start_edge  = s2_q & ~s1_q;
    assign data_bit_en = (state_q == S_DATA) & clk_bps;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shreg
            assign bit_sel[gi] = data_bit_en & (bit_cnt_q == 3'(gi));
            assign shreg_d[gi] = bit_sel[gi] ? s1_q : shreg_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= 8'h00;
        end else begin
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_bad = ^{shreg_q, parity_bit_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            bps_start_q  <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q     <= S_START;
                        bps_start_q <= 1'b1;
                        rx_busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_bps) begin
                        if (!s1_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            // Line back high at bit centre: treat as noise, release the generator.
                            state_q     <= S_IDLE;
                            bps_start_q <= 1'b0;
                            rx_busy_q   <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_bps) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_bps) begin
                        parity_bit_q <= s1_q;
                        state_q      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (clk_bps) begin
                        state_q     <= S_IDLE;
                        bps_start_q <= 1'b0;
                        rx_busy_q   <= 1'b0;
                        if (!s1_q) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    bps_start_q <= 1'b0;
                    rx_busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bps_start = bps_start_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
